da2dac: RTL and testbench
=========================

# da2dac

Pmod DA2 write controller: the output-side counterpart to the AD2 acquisition path. It accepts a 12-bit sample and channel mask from a generator over the same two-wire request/acknowledge handshake the ADC path uses. It serialises a 16-bit frame to the two DAC121S101 converters over a shared SYNC/SCLK with separate data lines, then acknowledges. It sits between a waveform/value generator module and the JA/JB Pmod pins at top level.

## Interface
- `CLKDIV`, default 4: SCLK half-period in CLK cycles. Legal range 2–255. The default gives 12.5 MHz at 100 MHz.
- `CLK` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `dacdav` in 1: write request, level-sensitive.
- `davdac` out 1: acknowledge, a one-cycle pulse.
- `dacdata` in 16: sample. Binary in [11:0], or 4 BCD digits in [15:0] (see Configuration).
- `dacch` in 2: channel mask. Bit 0 = DAC A, bit 1 = DAC B.
- `dacsync` out 1: SYNC, active low.
- `dacsclk` out 1: serial clock. Idles high.
- `dacdina` out 1: DAC A serial data.
- `dacdinb` out 1: DAC B serial data.

## Operation
- **Reset values:** `dacsync`=1, `dacsclk`=1, `dacdina`=0, `dacdinb`=0, `davdac`=0, state IDLE, bit counter 0, shadow registers A and B = 0.
- **Frame format, per DAC:** 2 don't-care bits (sent as 0), then PD1:PD0=00 (normal mode), then D11..D0. Sent MSB first, 16 bits total.
- **Shadow registers:** one 12-bit shadow per channel. On every frame, both data lines carry a full frame, because SYNC is shared.
  - A selected channel sends the new value and updates its shadow.
  - An unselected channel resends its shadow, so its output does not change.
- **States:**
  - **IDLE:** if `dacdav`=1, go to LOAD.
  - **LOAD (1 cycle):** latch `dacdata`/`dacch`, build both 16-bit shift words, update shadows.
    - If `dacch`=00, go to ACK with no frame generated.
    - Otherwise drive `dacsync`=0, put bit 15 on both DIN lines, and go to SHIFT.
  - **SHIFT:**
    - SCLK toggles every `CLKDIV` cycles, starting high.
    - The DAC samples on each falling edge. DIN changes only on rising edges, to the next bit.
    - After the 16th falling edge, wait `CLKDIV` cycles, drive `dacsclk`=1 and `dacsync`=1, then go to ACK.
  - **ACK (1 cycle):** `davdac`=1, DIN lines = 0, then go to GAP.
  - **GAP:** hold `CLKDIV` cycles (this is the minimum SYNC-high time), then go to IDLE.
- **Requests:**
  - The requester must deassert `dacdav` upon seeing `davdac`.
  - `dacdav` is sampled only in IDLE. Changes during LOAD through GAP are ignored.
  - If `dacdav` is still high when IDLE is re-entered, a new frame starts.
- **Binary mode:** `dacdata[15:12]` is ignored.

## Timing
- `dacdav` is sampled high in IDLE at cycle N. LOAD runs at N+1, and `dacsync` falls at N+2.
- `dacsync` stays low for exactly 32·`CLKDIV` cycles.
- `davdac` is high at the cycle `dacsync` returns high plus 1.
- The next `dacsync` fall is no earlier than `CLKDIV`+3 cycles after the previous rise.
- **`dacch`=00:** `davdac` pulses at N+2, and SYNC/SCLK stay idle.
- **Reset mid-frame:** on the next edge all outputs return to their reset values, including `dacsync`=1. The DAC discards the partial frame (fewer than 16 falling edges). Shadows clear to 0.
- **`reset` and `dacdav` high in the same cycle:** reset wins, and no frame starts that cycle.

## Configuration
- **`DA2_BCD_EN` defined:** `dacdata` is 4 BCD digits, thousands in [15:12] down to units in [3:0].
  - LOAD converts them to binary combinationally: d3·1000 + d2·100 + d1·10 + d0.
  - Any digit above 9 is treated as 9.
  - Results above 4095 saturate to 4095.
  - Latency is unchanged.
- **`DA2_BCD_EN` undefined:** binary mode only, as described in Operation.

## Test plan
- **Channel A write:** `CLKDIV`=4, reset, then `dacdata`=0x0ABC, `dacch`=01.
  - `dacdina` = 0000_1010_1011_1100 sampled on 16 falling edges.
  - `dacdinb` = all zeros.
  - SYNC low for 128 cycles, `davdac` one pulse.
- **Channel B, then both channels:** write `dacch`=10 with 0x0123, then `dacch`=11 with 0x0FFF.
  - The second frame carries 0x0FFF on both lines.
  - Writing `dacch`=01 with 0x0001 then resends the B shadow 0x0FFF on `dacdinb`.
- **Held request:** keep `dacdav` high for 400 cycles.
  - Back-to-back frames occur.
  - The SYNC-high gap between frames is at least `CLKDIV`+3 = 7 cycles.
  - There is one `davdac` per frame.
- **Reset mid-frame:** assert `reset` after the 5th falling SCLK edge.
  - The next cycle shows `dacsync`=1, `dacsclk`=1, DIN=0.
  - A following 0x0800 write to `dacch`=11 produces a full correct frame, and both shadows read back 0x800.
- **`dacch`=00:** `davdac` at N+2 and no SYNC activity.
- **BCD mode (`DA2_BCD_EN`):**
  - `dacdata`=0x4095 → binary 0xFFF.
  - 0x1234 → 0x4D2.
  - 0x9999 → saturates to 0xFFF.
  - 0x00A5 → digit clamped to 9, giving 95 = 0x05F.

Source files
------------

// File: rtl/da2dac_if.sv
// -----------------------------------------------------------------------------
// da2dac_if
// Groups the generator-side request/acknowledge bus and the Pmod DA2 pin
// bundle. The controller uses it through the slave modport. The
// generator (or a testbench) uses it through the master modport.
//
// Signals:
//   dacdav  - write request from the generator (level)
//   davdac  - one-cycle acknowledge back to the generator
//   dacdata - sample word (binary in [11:0], or 4 BCD digits)
//   dacch   - channel mask, bit 0 = DAC A, bit 1 = DAC B
//   dacsync - shared SYNC to both converters, active low
//   dacsclk - shared serial clock, idles high
//   dacdina - serial data to DAC A
//   dacdinb - serial data to DAC B
// -----------------------------------------------------------------------------
interface da2dac_if;
   logic        dacdav;
   logic        davdac;
   logic [15:0] dacdata;
   logic [1:0]  dacch;
   logic        dacsync;
   logic        dacsclk;
   logic        dacdina;
   logic        dacdinb;

   modport master (
      output dacdav,
      output dacdata,
      output dacch,
      input  davdac,
      input  dacsync,
      input  dacsclk,
      input  dacdina,
      input  dacdinb
   );

   modport slave (
      input  dacdav,
      input  dacdata,
      input  dacch,
      output davdac,
      output dacsync,
      output dacsclk,
      output dacdina,
      output dacdinb
   );
endinterface

// File: rtl/da2dac.sv
// -----------------------------------------------------------------------------
// da2dac
// Pmod DA2 write controller. It takes a 12-bit sample and a channel mask over
// the dacdav/davdac handshake. It shifts one 16-bit frame per converter
// (2 zero bits, PD1:PD0 = 00, D11..D0, MSB first) onto the two DAC121S101
// parts. The parts share SYNC/SCLK and each has its own data line.
// Each channel has a shadow register. A channel that is not selected resends
// its shadow, so its output holds while the other channel updates.
//
// Parameters:
//   CLKDIV - SCLK half-period in CLK cycles (2..255)
//
// Ports:
//   CLK   - system clock, rising edge
//   reset - synchronous, active-high reset
//   bus   - da2dac_if.slave (handshake, sample, channel mask, DAC pins)
//
// Optional build macro:
//   DA2_BCD_EN - when defined, dacdata carries 4 BCD digits. They are
//                converted to binary in LOAD, with each digit clamped to 9
//                and the result saturated at 4095.
// -----------------------------------------------------------------------------
module da2dac #(
   parameter int CLKDIV = 4
) (
   input logic   CLK,
   input logic   reset,
   da2dac_if.slave bus
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_ACK   = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;

   localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

   logic [2:0]  state;
   logic [7:0]  div_cnt;
   logic [5:0]  half_cnt;
   logic [15:0] shift_a;
   logic [15:0] shift_b;
   logic [11:0] shadow_a;
   logic [11:0] shadow_b;
   logic        sync;
   logic        sclk;
   logic        dina;
   logic        dinb;
   logic        ack;

   logic [11:0] sample;
   logic [11:0] next_a;
   logic [11:0] next_b;
   logic [15:0] word_a;
   logic [15:0] word_b;

`ifdef DA2_BCD_EN
   logic [3:0]  dig3;
   logic [3:0]  dig2;
   logic [3:0]  dig1;
   logic [3:0]  dig0;
   logic [13:0] bcd_sum;

   function automatic logic [3:0] clamp9(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   // Turn the four BCD digits into a binary value. An invalid digit is
   // clamped to 9 and anything above full scale is pinned at 4095. The
   // largest possible sum is 9999, so 14 bits are enough.
   always_comb begin
      dig3    = clamp9(bus.dacdata[15:12]);
      dig2    = clamp9(bus.dacdata[11:8]);
      dig1    = clamp9(bus.dacdata[7:4]);
      dig0    = clamp9(bus.dacdata[3:0]);
      bcd_sum = 14'(dig3) * 14'd1000 + 14'(dig2) * 14'd100
              + 14'(dig1) * 14'd10   + 14'(dig0);
      sample  = (bcd_sum > 14'd4095) ? 12'hFFF : bcd_sum[11:0];
   end
`else
   logic unused_hi;

   // In binary mode only the low 12 bits of dacdata are meaningful.
   always_comb begin
      sample = bus.dacdata[11:0];
   end

   assign unused_hi = ^bus.dacdata[15:12];
`endif

   // Choose what each data line carries in the coming frame. A selected
   // channel takes the new sample. Any other channel repeats its shadow,
   // because the shared SYNC forces both converters to receive a frame.
   always_comb begin
      next_a = bus.dacch[0] ? sample : shadow_a;
      next_b = bus.dacch[1] ? sample : shadow_b;
      word_a = {4'b0000, next_a};
      word_b = {4'b0000, next_b};
   end

   // Main sequencer. In SHIFT, div_cnt sets the SCLK half-period and
   // half_cnt counts SCLK toggles. There are 32 toggles in a frame:
   // 16 falling edges where the DAC samples, and 16 rising edges where the
   // next bit is presented. SYNC rises together with the 32nd toggle (the
   // final return of SCLK to high). The extra cycle at half_cnt == 32 places
   // the acknowledge one cycle after SYNC goes high.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state    <= ST_IDLE;
         div_cnt  <= 8'd0;
         half_cnt <= 6'd0;
         shift_a  <= 16'd0;
         shift_b  <= 16'd0;
         shadow_a <= 12'd0;
         shadow_b <= 12'd0;
         sync     <= 1'b1;
         sclk     <= 1'b1;
         dina     <= 1'b0;
         dinb     <= 1'b0;
         ack      <= 1'b0;
      end else begin
         ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.dacdav) begin
                  state <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               shadow_a <= next_a;
               shadow_b <= next_b;
               div_cnt  <= 8'd0;
               half_cnt <= 6'd0;
               if (bus.dacch == 2'b00) begin
                  state <= ST_ACK;
                  ack   <= 1'b1;
               end else begin
                  sync    <= 1'b0;
                  sclk    <= 1'b1;
                  dina    <= word_a[15];
                  dinb    <= word_b[15];
                  shift_a <= {word_a[14:0], 1'b0};
                  shift_b <= {word_b[14:0], 1'b0};
                  state   <= ST_SHIFT;
               end
            end

            ST_SHIFT: begin
               if (half_cnt == 6'd32) begin
                  state <= ST_ACK;
                  ack   <= 1'b1;
                  dina  <= 1'b0;
                  dinb  <= 1'b0;
               end else if (div_cnt == DIV_LAST) begin
                  div_cnt  <= 8'd0;
                  half_cnt <= half_cnt + 6'd1;
                  sclk     <= ~sclk;
                  // A low-to-high SCLK transition is where the next bit goes out
                  if (!sclk) begin
                     dina    <= shift_a[15];
                     dinb    <= shift_b[15];
                     shift_a <= {shift_a[14:0], 1'b0};
                     shift_b <= {shift_b[14:0], 1'b0};
                  end
                  if (half_cnt == 6'd31) begin
                     sync <= 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end

            ST_ACK: begin
               dina     <= 1'b0;
               dinb     <= 1'b0;
               div_cnt  <= 8'd0;
               half_cnt <= 6'd0;
               state    <= ST_GAP;
            end

            ST_GAP: begin
               // Keep SYNC high for at least CLKDIV cycles before the next frame can begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= 8'd0;
                  state   <= ST_IDLE;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.davdac  = ack;
   assign bus.dacsync = sync;
   assign bus.dacsclk = sclk;
   assign bus.dacdina = dina;
   assign bus.dacdinb = dinb;

endmodule

// File: tb/tb_da2dac.sv
// -----------------------------------------------------------------------------
// tb_da2dac
// Directed test bench for da2dac. The stimulus side pushes the expected frame
// contents for each request into a queue. A separate monitor rebuilds each
// frame from the DAC pins on the falling SCLK edges, and pops and compares an
// entry every time davdac pulses. Data words are chosen so that the expected
// 12-bit results are the same with or without DA2_BCD_EN.
// -----------------------------------------------------------------------------
module tb_da2dac;

   localparam int C = 4;

`ifdef DA2_BCD_EN
   localparam logic [15:0] D_ABC = 16'h2748;
   localparam logic [15:0] D_123 = 16'h0291;
   localparam logic [15:0] D_FFF = 16'h4095;
   localparam logic [15:0] D_001 = 16'h0001;
   localparam logic [15:0] D_555 = 16'h1365;
   localparam logic [15:0] D_AAA = 16'h2730;
   localparam logic [15:0] D_800 = 16'h2048;
   localparam logic [15:0] D_456 = 16'h1110;
`else
   localparam logic [15:0] D_ABC = 16'h0ABC;
   localparam logic [15:0] D_123 = 16'h0123;
   localparam logic [15:0] D_FFF = 16'h0FFF;
   localparam logic [15:0] D_001 = 16'h0001;
   localparam logic [15:0] D_555 = 16'h0555;
   localparam logic [15:0] D_AAA = 16'h0AAA;
   localparam logic [15:0] D_800 = 16'h0800;
   localparam logic [15:0] D_456 = 16'h0456;
`endif

   typedef struct packed {
      logic        has_frame;
      logic [15:0] a;
      logic [15:0] b;
   } exp_t;

   logic CLK = 1'b0;
   logic reset;
   da2dac_if bus();

   da2dac #(.CLKDIV(C)) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   exp_t exp_q[$];
   int   checks     = 0;
   int   failures   = 0;
   int   cyc        = 0;
   bit   abort_flag = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: rebuild frames from the pins and score each acknowledge
   logic        prev_sync   = 1'b1;
   logic        prev_sclk   = 1'b1;
   logic        prev_davdac = 1'b0;
   logic [15:0] cap_a, cap_b, frame_a, frame_b;
   int          nbits       = 0;
   int          low_cnt     = 0;
   int          rise_cyc    = 0;
   bit          have_rise   = 0;
   bit          frame_ready = 0;

   always @(negedge CLK) begin
      exp_t e;
      if (reset) begin
         prev_sync   = 1'b1;
         prev_sclk   = 1'b1;
         prev_davdac = 1'b0;
         nbits       = 0;
         have_rise   = 0;
         frame_ready = 0;
      end else begin
         if (prev_sync && !bus.dacsync) begin
            if (have_rise)
               check_output("sync_gap_min", 32'((cyc - rise_cyc) >= C + 3), 32'd1);
            low_cnt = 0;
            nbits   = 0;
         end
         if (!bus.dacsync) begin
            low_cnt++;
            if (prev_sclk && !bus.dacsclk) begin
               cap_a = {cap_a[14:0], bus.dacdina};
               cap_b = {cap_b[14:0], bus.dacdinb};
               nbits++;
            end
         end
         if (!prev_sync && bus.dacsync) begin
            if (abort_flag) begin
               nbits     = 0;
               have_rise = 0;
            end else begin
               check_output("frame_bits", 32'(nbits), 32'd16);
               check_output("sync_low_cycles", 32'(low_cnt), 32'(32 * C));
               frame_a     = cap_a;
               frame_b     = cap_b;
               frame_ready = 1;
               rise_cyc    = cyc;
               have_rise   = 1;
            end
         end
         if (bus.davdac) begin
            check_output("davdac_width", 32'(prev_davdac), 32'd0);
            if (exp_q.size() == 0) begin
               check_output("unexpected_davdac", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check_output("frame_present", 32'(frame_ready), 32'(e.has_frame));
               if (e.has_frame && frame_ready) begin
                  check_output("frame_dina", 32'(frame_a), 32'(e.a));
                  check_output("frame_dinb", 32'(frame_b), 32'(e.b));
                  check_output("ack_after_sync", 32'(cyc - rise_cyc), 32'd1);
               end
            end
            frame_ready = 0;
         end
         prev_sync   = bus.dacsync;
         prev_sclk   = bus.dacsclk;
         prev_davdac = bus.davdac;
      end
   end

   task automatic push_exp(input logic has_frame, input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      e.has_frame = has_frame;
      e.a         = a;
      e.b         = b;
      exp_q.push_back(e);
   endtask

   task automatic wait_ack(input string name);
      bit seen = 0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge CLK);
         if (bus.davdac) seen = 1;
      end
      check_output(name, 32'(seen), 32'd1);
   endtask

   task automatic apply_stimulus(input logic [15:0] data, input logic [1:0] ch,
                                 input logic [15:0] ea, input logic [15:0] eb);
      push_exp(1'b1, ea, eb);
      @(negedge CLK);
      bus.dacdav  = 1'b1;
      bus.dacdata = data;
      bus.dacch   = ch;
      wait_ack("ack_timeout");
      bus.dacdav = 1'b0;
      repeat (C + 6) @(negedge CLK);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int falls;
      logic ps;
      reset       = 1'b1;
      bus.dacdav  = 1'b0;
      bus.dacdata = 16'd0;
      bus.dacch   = 2'b00;
      repeat (3) @(negedge CLK);
      check_output("rst_sync", 32'(bus.dacsync), 32'd1);
      check_output("rst_sclk", 32'(bus.dacsclk), 32'd1);
      check_output("rst_dina", 32'(bus.dacdina), 32'd0);
      check_output("rst_dinb", 32'(bus.dacdinb), 32'd0);
      check_output("rst_davdac", 32'(bus.davdac), 32'd0);
      reset = 1'b0;
      repeat (3) @(negedge CLK);

      $display("[TB] channel A write with latency check");
      push_exp(1'b1, 16'h0ABC, 16'h0000);
      bus.dacdav  = 1'b1;
      bus.dacdata = D_ABC;
      bus.dacch   = 2'b01;
      @(negedge CLK);
      check_output("sync_at_n1", 32'(bus.dacsync), 32'd1);
      @(negedge CLK);
      check_output("sync_at_n2", 32'(bus.dacsync), 32'd0);
      check_output("sclk_at_n2", 32'(bus.dacsclk), 32'd1);
      wait_ack("ack_timeout");
      bus.dacdav = 1'b0;
      repeat (C + 6) @(negedge CLK);

      $display("[TB] channel B, both, then A with B resent");
      apply_stimulus(D_123, 2'b10, 16'h0ABC, 16'h0123);
      apply_stimulus(D_FFF, 2'b11, 16'h0FFF, 16'h0FFF);
      apply_stimulus(D_001, 2'b01, 16'h0001, 16'h0FFF);

      $display("[TB] empty channel mask");
      push_exp(1'b0, 16'h0000, 16'h0000);
      bus.dacdav  = 1'b1;
      bus.dacdata = 16'h0777;
      bus.dacch   = 2'b00;
      @(negedge CLK);
      check_output("ch00_davdac_n1", 32'(bus.davdac), 32'd0);
      @(negedge CLK);
      check_output("ch00_davdac_n2", 32'(bus.davdac), 32'd1);
      check_output("ch00_sync", 32'(bus.dacsync), 32'd1);
      check_output("ch00_sclk", 32'(bus.dacsclk), 32'd1);
      bus.dacdav = 1'b0;
      repeat (C + 6) @(negedge CLK);

`ifdef DA2_BCD_EN
      $display("[TB] BCD conversion vectors");
      apply_stimulus(16'h1234, 2'b01, 16'h04D2, 16'h0FFF);
      apply_stimulus(16'h9999, 2'b01, 16'h0FFF, 16'h0FFF);
      apply_stimulus(16'h00A5, 2'b01, 16'h005F, 16'h0FFF);
      apply_stimulus(16'h4095, 2'b10, 16'h005F, 16'h0FFF);
`else
      $display("[TB] binary mode ignores upper nibble");
      apply_stimulus(16'hF321, 2'b10, 16'h0001, 16'h0321);
`endif

      $display("[TB] held request for 400 cycles");
      push_exp(1'b1, 16'h0555, 16'h0555);
      push_exp(1'b1, 16'h0555, 16'h0555);
      push_exp(1'b1, 16'h0555, 16'h0555);
      bus.dacdav  = 1'b1;
      bus.dacdata = D_555;
      bus.dacch   = 2'b11;
      repeat (400) @(negedge CLK);
      bus.dacdav = 1'b0;
      repeat (200) @(negedge CLK);
      check_output("held_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] reset in the middle of a frame");
      bus.dacdav  = 1'b1;
      bus.dacdata = D_AAA;
      bus.dacch   = 2'b01;
      falls = 0;
      ps    = bus.dacsclk;
      for (int i = 0; i < 1000 && falls < 5; i++) begin
         @(negedge CLK);
         if (ps && !bus.dacsclk && !bus.dacsync) falls++;
         ps = bus.dacsclk;
      end
      check_output("five_falls_seen", 32'(falls), 32'd5);
      abort_flag = 1;
      reset      = 1'b1;
      @(negedge CLK);
      check_output("abort_sync", 32'(bus.dacsync), 32'd1);
      check_output("abort_sclk", 32'(bus.dacsclk), 32'd1);
      check_output("abort_dina", 32'(bus.dacdina), 32'd0);
      check_output("abort_dinb", 32'(bus.dacdinb), 32'd0);
      check_output("abort_davdac", 32'(bus.davdac), 32'd0);
      reset       = 1'b0;
      bus.dacdata = D_001;
      bus.dacch   = 2'b01;
      push_exp(1'b1, 16'h0001, 16'h0000);
      @(negedge CLK);
      abort_flag = 0;
      wait_ack("ack_timeout");
      bus.dacdav = 1'b0;
      repeat (C + 6) @(negedge CLK);

      $display("[TB] full frame after reset and shadow readback");
      apply_stimulus(D_800, 2'b11, 16'h0800, 16'h0800);
      apply_stimulus(D_123, 2'b01, 16'h0123, 16'h0800);
      apply_stimulus(D_456, 2'b10, 16'h0123, 16'h0456);

      repeat (20) @(negedge CLK);
      check_output("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
